// File: rtl/mvm_seq_ctrl_if.sv
// Job, buffer-read and engine handshake bundle for the matrix-vector sequencer.
// The controller takes the slave view; the job host / engine side takes master.
interface mvm_seq_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              i_start;
  logic              i_abort;
  logic [ADDR_W:0]   i_num_vec;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic              o_clr_mvm;
  logic              o_start_mvm;
  logic              i_busy_mvm;
  logic              o_busy;
  logic [ADDR_W:0]   o_vec_idx;
  logic              o_done_valid;
  logic              i_done_ready;
  logic              o_err;

  modport slave (
    input  i_start, i_abort, i_num_vec, i_busy_mvm, i_done_ready,
    output o_rd_en, o_rd_addr, o_clr_mvm, o_start_mvm, o_busy,
           o_vec_idx, o_done_valid, o_err
  );

  modport master (
    output i_start, i_abort, i_num_vec, i_busy_mvm, i_done_ready,
    input  o_rd_en, o_rd_addr, o_clr_mvm, o_start_mvm, o_busy,
           o_vec_idx, o_done_valid, o_err
  );
endinterface

// File: rtl/mvm_seq_ctrl.sv
// Sequences a matrix-vector job: clear accumulator, then per vector fetch,
// start the engine and wait out its busy pulse, with a per-operation watchdog.
module mvm_seq_ctrl #(
  parameter int NUM_VECTOR = 128,
  parameter int ADDR_W     = 7,
  parameter int TIMEOUT    = 1024
) (
  input  logic           i_clk_mvmSeqCtrl,
  input  logic           i_rst_mvmSeqCtrl,
  mvm_seq_ctrl_if.slave  bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  // The start cycle counts toward the budget, so the final wait cycle allowed
  // is the one where the counter (cleared in START) reads TIMEOUT-2.
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 2);
  localparam logic [ADDR_W:0]   NUM_MAX = (ADDR_W + 1)'(NUM_VECTOR);
  localparam logic [ADDR_W:0]   ONE     = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    IDLE, CLR, FETCH, LOAD, START, WAIT_HI, WAIT_LO, DONE
  } state_t;

  state_t            state, nxt;
  logic [ADDR_W:0]   num, idx, num_in;
  logic [WD_W-1:0]   wd;
  logic              err;
  logic              accept, idx_inc, wd_clr, wd_inc, err_set;

  always_ff @(posedge i_clk_mvmSeqCtrl or posedge i_rst_mvmSeqCtrl) begin
    if (i_rst_mvmSeqCtrl) state <= IDLE;
    else                  state <= nxt;
  end

  always_comb begin
    nxt     = state;
    accept  = 1'b0;
    idx_inc = 1'b0;
    wd_clr  = 1'b0;
    wd_inc  = 1'b0;
    err_set = 1'b0;
    num_in  = (bus.i_num_vec > NUM_MAX) ? NUM_MAX : bus.i_num_vec;
    if (state != IDLE && bus.i_abort) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start && !bus.i_abort) begin
            accept = 1'b1;
            nxt    = (num_in == '0) ? DONE : CLR;
          end
        end
        CLR:   nxt = FETCH;
        FETCH: nxt = LOAD;
        LOAD:  nxt = START;
        START: begin
          wd_clr = 1'b1;
          nxt    = WAIT_HI;
        end
        WAIT_HI: begin
          wd_inc = 1'b1;
          if (wd == WD_LAST) begin
            err_set = 1'b1;
            nxt     = DONE;
          end else if (bus.i_busy_mvm) begin
            nxt = WAIT_LO;
          end
        end
        WAIT_LO: begin
          wd_inc = 1'b1;
          if (wd == WD_LAST) begin
            err_set = 1'b1;
            nxt     = DONE;
          end else if (!bus.i_busy_mvm) begin
            if (idx == num - ONE) begin
              nxt = DONE;
            end else begin
              idx_inc = 1'b1;
              nxt     = FETCH;
            end
          end
        end
        DONE:    if (bus.i_done_ready) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk_mvmSeqCtrl or posedge i_rst_mvmSeqCtrl) begin
    if (i_rst_mvmSeqCtrl) begin
      num <= '0;
      idx <= '0;
      wd  <= '0;
      err <= 1'b0;
    end else begin
      if (accept) begin
        num <= num_in;
        idx <= '0;
        err <= 1'b0;
      end else if (idx_inc) begin
        idx <= idx + ONE;
      end
      if (wd_clr)      wd <= '0;
      else if (wd_inc) wd <= wd + WD_W'(1);
      if (err_set) err <= 1'b1;
    end
  end

  // Strobes are pure state decodes; abort/reset reach them only via the state.
  assign bus.o_clr_mvm    = (state == CLR);
  assign bus.o_rd_en      = (state == FETCH);
  assign bus.o_start_mvm  = (state == START);
  assign bus.o_done_valid = (state == DONE);
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_rd_addr    = idx[ADDR_W-1:0];
  assign bus.o_vec_idx    = idx;
  assign bus.o_err        = err;

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Directed bench for mvm_seq_ctrl: a per-cycle expected-output timeline built
// from job-level timing rules, plus literal checks on each scenario.
module tb_mvm_seq_ctrl;
  localparam int ADDR_W     = 7;
  localparam int NUM_VECTOR = 128;
  localparam int TIMEOUT    = 16;
  localparam int DEPTH      = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mvm_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mvm_seq_ctrl #(
    .NUM_VECTOR(NUM_VECTOR),
    .ADDR_W    (ADDR_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk_mvmSeqCtrl(clk),
    .i_rst_mvmSeqCtrl(rst),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // expected timeline, indexed by cycle number
  bit             e_clr  [DEPTH];
  bit             e_rd   [DEPTH];
  bit             e_start[DEPTH];
  bit             e_busy [DEPTH];
  bit             e_dv   [DEPTH];
  bit             e_err  [DEPTH];
  logic [ADDR_W:0] e_addr[DEPTH];

  // observations since the last job start
  int n_start, n_clr, n_rd, n_dv, last_addr, dv_first, err_rise, start_last;
  int addr_log[$];
  bit err_prev = 1'b0;

  int busy_len = 4;
  int rem      = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic clear_mon();
    n_start = 0; n_clr = 0; n_rd = 0; n_dv = 0;
    last_addr = -1; dv_first = -1; err_rise = -1; start_last = -1;
    addr_log.delete();
  endtask

  // Job-level timing: CLR one cycle after acceptance, vector v fetched at
  // s+2+v*P with P = 3 + 1 (WAIT_HI) + busy length (WAIT_LO), start two cycles
  // after each fetch, DONE where the next fetch would fall.
  task automatic plan_job(input int s, input int n, input int b, input int dlen, output int done);
    int nn, p, f;
    nn = (n > NUM_VECTOR) ? NUM_VECTOR : n;
    for (int k = s + 1; k < DEPTH; k++) e_err[k] = 1'b0;
    if (nn == 0) begin
      done = s + 1;
    end else begin
      e_clr[s + 1] = 1'b1;
      if (b == 0) begin
        e_rd[s + 2]   = 1'b1;
        e_addr[s + 2] = '0;
        e_start[s + 4] = 1'b1;
        done = s + 4 + TIMEOUT;
        for (int k = done; k < DEPTH; k++) e_err[k] = 1'b1;
      end else begin
        p = 4 + b;
        for (int v = 0; v < nn; v++) begin
          f = s + 2 + v * p;
          e_rd[f]        = 1'b1;
          e_addr[f]      = (ADDR_W + 1)'(v);
          e_start[f + 2] = 1'b1;
        end
        done = s + 2 + nn * p;
      end
    end
    for (int k = s + 1; k < done + dlen && k < DEPTH; k++) e_busy[k] = 1'b1;
    for (int k = done; k < done + dlen && k < DEPTH; k++) e_dv[k] = 1'b1;
  endtask

  task automatic idle_from(input int c);
    for (int k = c; k < DEPTH; k++) begin
      e_clr[k] = 1'b0; e_rd[k] = 1'b0; e_start[k] = 1'b0;
      e_busy[k] = 1'b0; e_dv[k] = 1'b0;
    end
  endtask

  task automatic start_job(input int n, input int b, input int dlen, output int s, output int done);
    @(negedge clk);
    busy_len      = b;
    bus.i_num_vec = (ADDR_W + 1)'(n);
    bus.i_start   = 1'b1;
    s = cyc;
    clear_mon();
    plan_job(s, n, b, dlen, done);
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic cmp_cycle(input int c);
    logic [5:0] act, expv;
    if (c >= DEPTH) return;
    act  = {bus.o_clr_mvm, bus.o_rd_en, bus.o_start_mvm, bus.o_busy, bus.o_done_valid, bus.o_err};
    expv = {e_clr[c], e_rd[c], e_start[c], e_busy[c], e_dv[c], e_err[c]};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL cycle %0d {clr,rd,start,busy,dv,err}: got %b want %b", c, act, expv);
    end
    if (e_rd[c]) begin
      checks++;
      if (bus.o_rd_addr !== e_addr[c][ADDR_W-1:0] || bus.o_vec_idx !== e_addr[c]) begin
        errors++;
        $display("FAIL cycle %0d rd_addr/vec_idx: got %0d/%0d want %0d",
                 c, bus.o_rd_addr, bus.o_vec_idx, e_addr[c]);
      end
    end
    if (bus.o_start_mvm) begin n_start++; start_last = c; end
    if (bus.o_clr_mvm) n_clr++;
    if (bus.o_rd_en) begin n_rd++; last_addr = int'(bus.o_rd_addr); addr_log.push_back(last_addr); end
    if (bus.o_done_valid) begin n_dv++; if (dv_first < 0) dv_first = c; end
    if (bus.o_err && !err_prev) err_rise = c;
    err_prev = bus.o_err;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      cmp_cycle(cyc);
    end
  end

  // engine: busy for busy_len cycles starting the cycle after each start pulse
  initial begin
    bus.i_busy_mvm = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rem > 0) begin bus.i_busy_mvm = 1'b1; rem--; end
      else bus.i_busy_mvm = 1'b0;
      if (bus.o_start_mvm) rem = busy_len;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    int s, done;
    bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_num_vec = '0; bus.i_done_ready = 1'b1;
    clear_mon();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("reset_state", 32'({bus.o_busy, bus.o_done_valid, bus.o_err, bus.o_rd_en,
                              bus.o_start_mvm, bus.o_clr_mvm, bus.o_vec_idx}), 0);
    rst = 1'b0;
    @(negedge clk);

    // three vectors, engine busy 4 cycles
    start_job(3, 4, 1, s, done);
    wait_until(done + 3);
    check("t1_clr_count", n_clr, 1);
    check("t1_start_count", n_start, 3);
    check("t1_rd_count", addr_log.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < addr_log.size()) check("t1_rd_addr", addr_log[i], i);
    check("t1_done_latency", dv_first - s, 26);
    check("t1_err", 32'(bus.o_err), 0);

    // empty job
    start_job(0, 4, 1, s, done);
    wait_until(done + 3);
    check("t2_done_latency", dv_first - s, 1);
    check("t2_start_count", n_start, 0);
    check("t2_rd_count", n_rd, 0);

    // oversize job clamps to NUM_VECTOR
    start_job(200, 1, 1, s, done);
    wait_until(done + 3);
    check("t3_start_count", n_start, 128);
    check("t3_last_addr", last_addr, 127);
    check("t3_done_latency", dv_first - s, 642);

    // watchdog: engine never goes busy
    start_job(1, 0, 1, s, done);
    wait_until(done + 5);
    check("t4_err_after_start", err_rise - start_last, 16);
    check("t4_done_latency", dv_first - s, 20);
    check("t4_dv_count", n_dv, 1);
    check("t4_err_held", 32'(bus.o_err), 1);

    // abort during WAIT_LO of vector 2
    start_job(4, 4, 1, s, done);
    wait_until(s + 23);
    check("t5_idx_at_abort", 32'(bus.o_vec_idx), 2);
    bus.i_abort = 1'b1;
    idle_from(s + 24);
    @(negedge clk);
    bus.i_abort = 1'b0;
    check("t5_busy_after_abort", 32'(bus.o_busy), 0);
    wait_until(s + 32);
    check("t5_dv_count", n_dv, 0);
    check("t5_start_count", n_start, 3);

    // abort wins over start in IDLE
    @(negedge clk);
    bus.i_num_vec = 8'd3; bus.i_start = 1'b1; bus.i_abort = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_abort = 1'b0;
    check("t5_abort_priority", 32'(bus.o_busy), 0);

    start_job(2, 4, 1, s, done);
    wait_until(done + 3);
    check("t5_next_start_count", n_start, 2);
    check("t5_next_done_latency", dv_first - s, 18);

    // done held while ready is low; start ignored meanwhile
    bus.i_done_ready = 1'b0;
    start_job(2, 4, 10, s, done);
    wait_until(done + 3);
    bus.i_num_vec = 8'd5; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_until(done + 9);
    bus.i_done_ready = 1'b1;
    wait_until(done + 14);
    check("t6_dv_cycles", n_dv, 10);
    check("t6_start_count", n_start, 2);
    check("t6_clr_count", n_clr, 1);

    // reset mid-job
    start_job(3, 4, 1, s, done);
    wait_until(s + 10);
    rst = 1'b1;
    #1;
    check("t7_reset_outputs", 32'({bus.o_busy, bus.o_done_valid, bus.o_err, bus.o_rd_en,
                                   bus.o_start_mvm, bus.o_clr_mvm, bus.o_vec_idx}), 0);
    idle_from(s + 11);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    wait_until(s + 40);
    check("t7_dv_count", n_dv, 0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
